// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl
//
// Data-memory responder for the MEM stage of the 5-stage ARM pipeline. Each
// 32-bit load/store is served from an external 16-bit asynchronous SRAM as two
// halfword phases (low half, then high half), each lasting WAIT_CYCLES clocks.
// While an access is in flight `ready` is low; the pipeline top ORs ~ready
// into its freeze signal.
//
// Optional feature (macro SRAM_CTRL_LAST_READ_BUF_EN):
//   one-entry buffer of the last word read. A read hitting the buffer completes
//   in the cycle after the request, without touching the SRAM. Any accepted
//   write invalidates it. With the macro undefined, no buffer logic exists.
//
// Parameters:
//   WAIT_CYCLES  clocks per halfword phase (1..15)
//   BASE_ADDR    byte address mapped to SRAM halfword 0
//   SRAM_AW      SRAM halfword address width
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   wr_en        store request from MEM stage
//   rd_en        load request from MEM stage
//   address      byte address (ALU result); bits [1:0] ignored
//   wdata        store data
//   rdata        load data, registered, held until the next read completes
//   ready        1 = no access pending, or access completing this cycle
//   sram_addr    SRAM halfword address (registered)
//   sram_dq_out  write data to SRAM pads (registered)
//   sram_dq_in   read data from SRAM pads
//   sram_dq_oe   pad output enable, 1 = drive
//   sram_we_n    SRAM write strobe, active low
//   sram_oe_n    SRAM output enable, active low
// ---------------------------------------------------------------------------
module sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int          WW         = SRAM_AW - 1;
    localparam logic [3:0]  PHASE_LAST = 4'(WAIT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 op_wr_q;        // latched operation: 1 = write
    logic [WW-1:0]        w_q;            // latched word index
    logic [15:0]          wdata_hi_q;     // high store half, driven in HI
    logic [15:0]          lo_q;           // low read half, sampled end of LO
    logic [31:0]          rdata_q;        // upper half doubles as the HI sample
    logic [SRAM_AW-1:0]   sram_addr_q;
    logic [15:0]          dq_out_q;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [31:0]   offset;
    logic [WW-1:0] req_w;
    logic          req;
    logic          phase_last;
    logic          buf_hit;

    assign offset     = address - 32'(BASE_ADDR);
    // Word index: byte offset / 4, truncated to the word-address width.
    assign req_w      = WW'(offset >> 2);
    assign req        = wr_en | rd_en;
    assign phase_last = (cnt_q == PHASE_LAST);

`ifdef SRAM_CTRL_LAST_READ_BUF_EN
    // ------------------------------------------------------------------
    // Last-read buffer
    // ------------------------------------------------------------------
    logic          buf_valid_q;
    logic [WW-1:0] buf_w_q;
    logic [31:0]   buf_data_q;

    // A simultaneous wr_en/rd_en is a write, so it never hits.
    assign buf_hit = rd_en & ~wr_en & buf_valid_q & (buf_w_q == req_w);

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_w_q     <= '0;
            buf_data_q  <= '0;
        end else if ((state_q == ST_IDLE) && wr_en) begin
            // Write accepted here always proceeds to LO.
            buf_valid_q <= 1'b0;
        end else if ((state_q == ST_HI) && phase_last && !op_wr_q) begin
            buf_valid_q <= 1'b1;
            buf_w_q     <= w_q;
            buf_data_q  <= {sram_dq_in, lo_q};
        end
    end
`else
    assign buf_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and phase counter
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = 4'd0;
                if (req) begin
                    state_d = buf_hit ? ST_DONE : ST_LO;
                end
            end
            ST_LO: begin
                if (phase_last) begin
                    state_d = ST_HI;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_HI: begin
                if (phase_last) begin
                    state_d = ST_DONE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_DONE: begin
                // Requests seen here are ignored: the pipeline advances on
                // this edge, so the next request is sampled back in IDLE.
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready      = 1'b0;
        sram_dq_oe = 1'b0;
        sram_we_n  = 1'b1;
        sram_oe_n  = 1'b1;
        case (state_q)
            ST_IDLE: begin
                ready = ~req;
            end
            ST_LO, ST_HI: begin
                ready      = 1'b0;
                sram_dq_oe = op_wr_q;
                sram_we_n  = ~op_wr_q;
                sram_oe_n  = op_wr_q;
            end
            ST_DONE: begin
                ready = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: request latch, SRAM address/data, read capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op_wr_q     <= 1'b0;
            w_q         <= '0;
            wdata_hi_q  <= '0;
            lo_q        <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        op_wr_q    <= wr_en;
                        w_q        <= req_w;
                        wdata_hi_q <= wdata[31:16];
                        if (buf_hit) begin
`ifdef SRAM_CTRL_LAST_READ_BUF_EN
                            rdata_q <= buf_data_q;
`endif
                        end else begin
                            // Present the low-half address (and store data)
                            // from the first LO cycle onward.
                            sram_addr_q <= {req_w, 1'b0};
                            if (wr_en) begin
                                dq_out_q <= wdata[15:0];
                            end
                        end
                    end
                end
                ST_LO: begin
                    if (phase_last) begin
                        sram_addr_q <= {w_q, 1'b1};
                        if (op_wr_q) begin
                            dq_out_q <= wdata_hi_q;
                        end else begin
                            lo_q <= sram_dq_in;
                        end
                    end
                end
                ST_HI: begin
                    // Load the whole word on the last HI edge so rdata is
                    // already valid during DONE.
                    if (phase_last && !op_wr_q) begin
                        rdata_q <= {sram_dq_in, lo_q};
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rdata       = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl
//
// Directed bench for sram_ctrl at the default parameters. A behavioural SRAM
// model answers the pads. Each request pushes its expected latency (cycles of
// ready low) and expected rdata into a scoreboard; a monitor on the falling
// edge pops and compares whenever an access completes (ready returns high).
// Pin-level timing is checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en;
    logic [31:0] address, wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic [15:0] sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    always #5 clk = ~clk;

    sram_ctrl #(
        .WAIT_CYCLES (2),
        .BASE_ADDR   (1024),
        .SRAM_AW     (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .address     (address),
        .wdata       (wdata),
        .rdata       (rdata),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_in  (sram_dq_in),
        .sram_dq_oe  (sram_dq_oe),
        .sram_we_n   (sram_we_n),
        .sram_oe_n   (sram_oe_n)
    );

    // Behavioural asynchronous SRAM (small window of the address space).
    logic [15:0] mem [0:63];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    end
    always @(posedge clk) begin
        if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
    end
    assign sram_dq_in = sram_oe_n ? 16'h0000 : mem[sram_addr[5:0]];

`ifdef SRAM_CTRL_LAST_READ_BUF_EN
    localparam int HIT_LAT = 1;
`else
    localparam int HIT_LAT = 5;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Scoreboard
    int          lat_q [$];
    logic [31:0] rd_q  [$];
    string       nm_q  [$];
    logic [31:0] exp_last = 32'h0;

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int          low_cnt = 0;
    int          mon_lat;
    logic [31:0] mon_rd;
    string       mon_nm;

    always @(negedge clk) begin
        if (rst) begin
            low_cnt = 0;
        end else if (!ready) begin
            low_cnt++;
        end else if (low_cnt > 0) begin
            if (lat_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: completion after %0d cycles, none expected", low_cnt);
            end else begin
                mon_lat = lat_q.pop_front();
                mon_rd  = rd_q.pop_front();
                mon_nm  = nm_q.pop_front();
                compared++;
                if (low_cnt != mon_lat) begin
                    mismatched++;
                    $display("FAIL %s_latency: got %0d expected %0d", mon_nm, low_cnt, mon_lat);
                end
                compared++;
                if (rdata !== mon_rd) begin
                    mismatched++;
                    $display("FAIL %s_rdata: got %h expected %h", mon_nm, rdata, mon_rd);
                end
                $display("txn %-12s latency %0d rdata %h", mon_nm, low_cnt, rdata);
            end
            low_cnt = 0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic expect_txn(input string nm, input int lat, input logic [31:0] rd);
        lat_q.push_back(lat);
        rd_q.push_back(rd);
        nm_q.push_back(nm);
    endtask

    // Present a request for one cycle (cycle 0), then scramble the inputs
    // with requests off. Returns 1 ns into cycle 1.
    task automatic req(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        wr_en   = w;
        rd_en   = r;
        address = a;
        wdata   = d;
        cyc();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        address = $urandom;
        wdata   = $urandom;
    endtask

    // Wait (bounded) for the completing cycle, then step into IDLE.
    task automatic wait_done(input string nm);
        int n = 0;
        while (ready !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        chk({nm, "_done_seen"}, {31'b0, ready}, 32'h1);
        cyc();
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        address = 32'h0;
        wdata   = 32'h0;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // Reset / idle state
        chk("rst_ready",     {31'b0, ready},      32'h1);
        chk("rst_we_n",      {31'b0, sram_we_n},  32'h1);
        chk("rst_oe_n",      {31'b0, sram_oe_n},  32'h1);
        chk("rst_dq_oe",     {31'b0, sram_dq_oe}, 32'h0);
        chk("rst_rdata",     rdata,               32'h0);
        chk("rst_sram_addr", {14'b0, sram_addr},  32'h0);

        // Write 0xDEADBEEF to byte 1032 -> halfwords 4 (BEEF) and 5 (DEAD)
        expect_txn("wr_1032", 5, exp_last);
        req(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("wr_addr_c%0d", c), {14'b0, sram_addr}, (c <= 2) ? 32'd4 : 32'd5);
            chk($sformatf("wr_dq_c%0d", c), {16'b0, sram_dq_out}, (c <= 2) ? 32'hBEEF : 32'hDEAD);
            chk($sformatf("wr_we_n_c%0d", c), {31'b0, sram_we_n}, 32'h0);
            chk($sformatf("wr_ready_c%0d", c), {31'b0, ready}, 32'h0);
            if (c == 1) begin
                chk("wr_dq_oe", {31'b0, sram_dq_oe}, 32'h1);
                chk("wr_oe_n",  {31'b0, sram_oe_n},  32'h1);
            end
            cyc();
        end
        chk("wr_ready_c5", {31'b0, ready}, 32'h1);
        cyc();
        chk("wr_idle_we_n",  {31'b0, sram_we_n},  32'h1);
        chk("wr_idle_dq_oe", {31'b0, sram_dq_oe}, 32'h0);

        // Read it back
        exp_last = 32'hDEADBEEF;
        expect_txn("rd_1032", 5, exp_last);
        req(1'b0, 1'b1, 32'd1032, 32'h0);
        chk("rd_oe_n_c1",  {31'b0, sram_oe_n},  32'h0);
        chk("rd_we_n_c1",  {31'b0, sram_we_n},  32'h1);
        chk("rd_dq_oe_c1", {31'b0, sram_dq_oe}, 32'h0);
        chk("rd_addr_c1",  {14'b0, sram_addr},  32'd4);
        wait_done("rd_1032");
        repeat (3) cyc();
        chk("rd_held", rdata, 32'hDEADBEEF);

        // Back-to-back: write request held through DONE
        expect_txn("b2b_a", 5, exp_last);
        expect_txn("b2b_b", 5, exp_last);
        wr_en   = 1'b1;
        address = 32'd1056;
        wdata   = 32'h55AA33CC;
        repeat (5) cyc();
        chk("b2b_done_ready", {31'b0, ready},     32'h1);
        chk("b2b_done_we_n",  {31'b0, sram_we_n}, 32'h1);
        cyc();
        chk("b2b_idle_ready", {31'b0, ready},     32'h0);
        chk("b2b_idle_we_n",  {31'b0, sram_we_n}, 32'h1);
        cyc();
        wr_en = 1'b0;
        chk("b2b_lo_we_n", {31'b0, sram_we_n}, 32'h0);
        wait_done("b2b");

        // Both enables high -> write
        expect_txn("both_1040", 5, exp_last);
        req(1'b1, 1'b1, 32'd1040, 32'h12345678);
        chk("both_we_n",  {31'b0, sram_we_n},  32'h0);
        chk("both_dq_oe", {31'b0, sram_dq_oe}, 32'h1);
        chk("both_addr",  {14'b0, sram_addr},  32'd8);
        wait_done("both_1040");
        exp_last = 32'h12345678;
        expect_txn("rd_1040", 5, exp_last);
        req(1'b0, 1'b1, 32'd1040, 32'h0);
        wait_done("rd_1040");

        // Reset during HI of a write to 1048 (halfwords 12/13)
        req(1'b1, 1'b0, 32'd1048, 32'hCAFEF00D);
        cyc();
        cyc();
        chk("abort_hi_addr", {14'b0, sram_addr}, 32'd13);
        chk("abort_hi_we_n", {31'b0, sram_we_n}, 32'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_last = 32'h0;
        chk("abort_we_n",  {31'b0, sram_we_n},  32'h1);
        chk("abort_dq_oe", {31'b0, sram_dq_oe}, 32'h0);
        chk("abort_rdata", rdata,               32'h0);
        chk("abort_ready", {31'b0, ready},      32'h1);
        cyc();
        // The model wrote both halves before the reset edge took effect.
        exp_last = 32'hCAFEF00D;
        expect_txn("rd_1048", 5, exp_last);
        req(1'b0, 1'b1, 32'd1048, 32'h0);
        wait_done("rd_1048");

        // Repeat read: buffered with the option, full access without
        exp_last = 32'hDEADBEEF;
        expect_txn("rd_1032_a", 5, exp_last);
        req(1'b0, 1'b1, 32'd1032, 32'h0);
        wait_done("rd_1032_a");
        expect_txn("rd_1032_b", HIT_LAT, exp_last);
        req(1'b0, 1'b1, 32'd1032, 32'h0);
        chk("rep_oe_n_c1", {31'b0, sram_oe_n}, (HIT_LAT == 1) ? 32'h1 : 32'h0);
        wait_done("rd_1032_b");

        // Write invalidates the buffer; following read is a full access
        expect_txn("wr_1032_b", 5, exp_last);
        req(1'b1, 1'b0, 32'd1032, 32'h0BADC0DE);
        wait_done("wr_1032_b");
        exp_last = 32'h0BADC0DE;
        expect_txn("rd_1032_c", 5, exp_last);
        req(1'b0, 1'b1, 32'd1032, 32'h0);
        wait_done("rd_1032_c");

        repeat (3) cyc();
        chk("sb_drained", lat_q.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
